// File: rtl/serial_dispatcher.sv
// serial_dispatcher: two ping-pong brick buffers loaded one window per beat,
// drained as LSB-first bit-slices spanning every window and lane.
//
// state    | meaning
// EMPTY    | free, mask clear, may be the fill target
// FILL     | fill target with at least one beat written
// FULL     | closed, waiting for the drain side
// DRAIN    | streaming slices; slice_cnt counts down to the last slice
module serial_dispatcher #(
   parameter int WL      = 16,
   parameter int LANES   = 16,
   parameter int WINDOWS = 16,
   parameter int PW      = 5
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              i_load_valid,
   output logic                              o_load_ready,
   input  logic [$clog2(WINDOWS)-1:0]        i_load_win,
   input  logic [LANES*WL-1:0]               i_load_brick,
   input  logic                              i_load_last,
   input  logic [PW-1:0]                     i_prec,
   output logic                              o_stream_valid,
   input  logic                              i_stream_ready,
   output logic [WINDOWS*LANES-1:0]          o_stream,
   output logic                              o_stream_last,
   output logic [WINDOWS-1:0]                o_win_mask
);

   localparam int JW = $clog2(WL);

   typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_FULL, ST_DRAIN} buf_state_t;

   buf_state_t         buf_state [2];
   buf_state_t         buf_state_nxt [2];
   logic               fill_sel, fill_sel_nxt;
   logic               drain_sel, drain_sel_nxt;
   logic [JW-1:0]      slice_cnt, slice_cnt_nxt;
   logic [PW-1:0]      prec [2];
   logic [PW-1:0]      prec_nxt [2];
   logic [WINDOWS-1:0] mask [2];
   logic [WINDOWS-1:0] mask_nxt [2];
   logic [WL-1:0]      mem [2][WINDOWS][LANES];
   logic [WL-1:0]      brick_word [LANES];
   logic [PW-1:0]      prec_norm;
   logic [JW-1:0]      bit_sel;
   logic               load_fire, load_close, drain_active, slice_fire, slice_tc;

   assign drain_active = (buf_state[drain_sel] == ST_DRAIN);
   assign slice_tc     = (slice_cnt == '0);
   assign slice_fire   = drain_active && i_stream_ready;
   assign o_load_ready = (buf_state[fill_sel] == ST_EMPTY) || (buf_state[fill_sel] == ST_FILL);
   assign load_fire    = i_load_valid && o_load_ready;
   assign load_close   = load_fire && i_load_last;
   assign prec_norm    = ((i_prec == '0) || (i_prec > PW'(WL))) ? PW'(WL) : i_prec;

   // slice_cnt runs P-1 down to 0, so the bit index is its distance from P-1
   assign bit_sel = JW'(prec[drain_sel] - PW'(1) - PW'(slice_cnt));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            buf_state[b] <= ST_EMPTY;
            prec[b]      <= PW'(WL);
            mask[b]      <= '0;
         end
         fill_sel  <= 1'b0;
         drain_sel <= 1'b0;
         slice_cnt <= '0;
      end else begin
         buf_state <= buf_state_nxt;
         prec      <= prec_nxt;
         mask      <= mask_nxt;
         fill_sel  <= fill_sel_nxt;
         drain_sel <= drain_sel_nxt;
         slice_cnt <= slice_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (load_fire) mem[fill_sel][i_load_win] <= brick_word;
   end

   // Closes alternate between buffers, so draining in alternating order
   // always takes the earlier-closed buffer first.
   always_comb begin
      buf_state_nxt = buf_state;
      prec_nxt      = prec;
      mask_nxt      = mask;
      fill_sel_nxt  = fill_sel;
      drain_sel_nxt = drain_sel;
      slice_cnt_nxt = slice_cnt;
      if (load_fire) begin
         buf_state_nxt[fill_sel]       = ST_FILL;
         mask_nxt[fill_sel][i_load_win] = 1'b1;
      end
      if (load_close) begin
         buf_state_nxt[fill_sel] = ST_FULL;
         prec_nxt[fill_sel]      = prec_norm;
         fill_sel_nxt            = ~fill_sel;
      end
      if (slice_fire) begin
         if (slice_tc) begin
            buf_state_nxt[drain_sel] = ST_EMPTY;
            mask_nxt[drain_sel]      = '0;
            drain_sel_nxt            = ~drain_sel;
         end else begin
            slice_cnt_nxt = slice_cnt - JW'(1);
         end
      end
      if (buf_state_nxt[drain_sel_nxt] == ST_FULL) begin
         buf_state_nxt[drain_sel_nxt] = ST_DRAIN;
         slice_cnt_nxt = JW'(prec_nxt[drain_sel_nxt] - PW'(1));
      end
   end

   assign o_stream_valid = drain_active;
   assign o_stream_last  = drain_active && slice_tc;
   assign o_win_mask     = drain_active ? mask[drain_sel] : '0;

   for (genvar k = 0; k < LANES; k++) begin : g_brick
      assign brick_word[k] = i_load_brick[k*WL +: WL];
   end

   for (genvar w = 0; w < WINDOWS; w++) begin : g_win
      for (genvar k = 0; k < LANES; k++) begin : g_lane
         assign o_stream[w*LANES+k] = drain_active && mask[drain_sel][w] &&
                                      mem[drain_sel][w][k][bit_sel];
      end
   end

endmodule

// File: doc/serial_dispatcher.md
SERIAL_DISPATCHER -- requirements
Module: serial_dispatcher

Interface
REQ-001 Parameters SHALL be: WL, default 16, word length in bits; LANES, default 16, words per brick; WINDOWS, default 16, parallel windows (bricks per buffer); PW, default 5, precision field width (WL representable).
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_load_valid  in  1  load beat offered.
- o_load_ready  out  1  fill buffer can accept a beat.
- i_load_win  in  clog2(WINDOWS)  target window of the beat.
- i_load_brick  in  LANES*WL  brick; word k at bits [k*WL +: WL].
- i_load_last  in  1  beat closes the current fill buffer.
- i_prec  in  PW  precision P for the buffer being closed.
- o_stream_valid  out  1  o_stream holds a valid bit-slice.
- i_stream_ready  in  1  consumer accepts the slice.
- o_stream  out  WINDOWS*LANES  bit-slice; bit w*LANES+k = current bit of word k, window w.
- o_stream_last  out  1  final slice of the buffer.
- o_win_mask  out  WINDOWS  windows written in the draining buffer.

Function
REQ-003 The block SHALL hold two ping-pong buffers (B0, B1), each WINDOWS x LANES x WL bits plus a WINDOWS-bit written mask and a latched precision.
REQ-004 Each buffer SHALL be in EMPTY, FILL, FULL, or DRAIN; exactly one buffer is the fill target (FILL or EMPTY) unless both are FULL/DRAIN.
REQ-005 A load beat SHALL transfer when i_load_valid and o_load_ready are high on a rising edge; the brick is written to i_load_win of the fill buffer and that window's mask bit is set.
REQ-006 A repeated write to the same window before closing SHALL overwrite it.
REQ-007 A transfer with i_load_last high SHALL mark the fill buffer FULL and latch P = i_prec, with P=0 or P>WL stored as WL.
REQ-008 o_load_ready SHALL be low when no buffer is EMPTY or in FILL.
REQ-009 A FULL buffer SHALL enter DRAIN on the cycle the drain side is idle; the first slice is valid on the next cycle (load_last to first o_stream_valid latency = 1 cycle when idle).
REQ-010 If both buffers are FULL, the buffer closed earlier SHALL drain first.
REQ-011 In DRAIN, slice j (j = 0..P-1) SHALL carry bit j (LSB first) of every word; unwritten windows output 0.
REQ-012 A slice SHALL advance only when o_stream_valid and i_stream_ready are both high; while stalled, o_stream, o_stream_last, and o_win_mask hold stable.
REQ-013 o_stream_last SHALL be high exactly on slice P-1; its acceptance returns the buffer to EMPTY and clears its mask.
REQ-014 If another buffer is FULL when the last slice is accepted, its slice 0 SHALL be valid the next cycle (no bubble).
REQ-015 A load_last and a last-slice acceptance in the same cycle SHALL both take effect; the freed buffer becomes the fill target.
REQ-016 o_win_mask SHALL reflect the draining buffer, and be 0 when not draining.
REQ-017 o_stream_valid SHALL not depend combinationally on i_stream_ready.

Reset
REQ-018 Asserting rst_n low SHALL immediately set both buffers EMPTY, B0 as the fill target, all masks to 0, and o_stream_valid, o_stream_last, o_stream, o_win_mask to 0, with o_load_ready going high after release.
REQ-019 Reset mid-fill or mid-drain SHALL discard all buffered data; buffer word contents need not be cleared.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Load 16 windows, word = window*16+lane, P=16, ready held high -> 16 consecutive slices, slice j bit w*16+k = bit j of (w*16+k); last on slice 15.
- Load windows 0 and 3 only, P=4 -> 4 slices; o_win_mask = 0x0009; all other windows' bits are 0.
- i_prec = 0 and i_prec = 20 -> 16 slices each.
- Fill B0 and B1 while stream ready is low -> o_load_ready low after the second load_last; B0 drains before B1 with no bubble between them; ready rises after B0's last slice.
- Random i_stream_ready stalls -> slice sequence identical to the unstalled run; outputs stable during stalls.
- rst_n low at slice 5 of a drain -> valid drops immediately; after release, a new P=2 load streams 2 correct slices.
